// File: rtl/pl_irq_pkg.sv
// Shared types and constants for the periodic PL->PS interrupt timer array.
// Optional miss counter is enabled with PL_IRQ_MISS_CNT_EN.
package pl_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } irq_state_e;

    localparam logic        MODE_PULSE = 1'b0;
    localparam logic        MODE_LEVEL = 1'b1;
    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned MISS_W     = 8;

    function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] v);
        return (v == {MISS_W{1'b1}}) ? v : v + MISS_W'(1);
    endfunction

endpackage

// File: rtl/pl_irq_chan.sv
// One interrupt channel: period counter, shadow config, IDLE/RUN/HOLD FSM and overrun flag.
// Build with PL_IRQ_MISS_CNT_EN to add the saturating per-channel miss counter.
module pl_irq_chan
    import pl_irq_pkg::*;
#(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned DEF_PERIOD = 600000,
    parameter int unsigned PULSE_CYC  = 200
) (
    input  logic             Sys_clk,
    input  logic             Rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic             wr_mode,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             irq,
`ifdef PL_IRQ_MISS_CNT_EN
    output logic [MISS_W-1:0] miss_cnt,
`endif
    output logic             overrun
);

    irq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] shd_period_r;
    logic [CNT_W-1:0] pulse_r;
    logic             mode_r;
    logic             shd_mode_r;
    logic             shd_valid_r;
    logic             irq_r;
    logic             ovr_r;

    logic [CNT_W-1:0] wr_period_s;
    logic [CNT_W-1:0] ld_period_s;
    logic [CNT_W-1:0] nxt_period_s;
    logic [CNT_W-1:0] pm1_s;
    logic [CNT_W-1:0] pw_s;
    logic             ld_mode_s;
    logic             ld_valid_s;
    logic             nxt_mode_s;
    logic             tick_s;
    logic             mode_chg_s;
    logic             ovr_set_s;

    // Config source selection (a write this cycle beats the older shadow), tick and overrun decode.
    always_comb begin
        wr_period_s = (wr_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : wr_period;
        tick_s      = (state_r != IDLE) && (cnt_r == period_r - CNT_W'(1));
        if (wr) begin
            ld_valid_s  = 1'b1;
            ld_period_s = wr_period_s;
            ld_mode_s   = wr_mode;
        end else begin
            ld_valid_s  = shd_valid_r;
            ld_period_s = shd_period_r;
            ld_mode_s   = shd_mode_r;
        end
        nxt_period_s = ld_valid_s ? ld_period_s : period_r;
        nxt_mode_s   = ld_valid_s ? ld_mode_s : mode_r;
        pm1_s        = nxt_period_s - CNT_W'(1);
        // Pulse width is clamped to P-1 so the line always drops once per period.
        pw_s         = (32'(pm1_s) < PULSE_CYC) ? pm1_s : CNT_W'(PULSE_CYC);
        mode_chg_s   = ld_valid_s && (ld_mode_s != mode_r);
        ovr_set_s    = en && tick_s && (state_r == HOLD) && !ack && !mode_chg_s;
    end

    // Channel FSM with counter, shadow load at wrap and registered interrupt line.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            period_r     <= CNT_W'(DEF_PERIOD);
            mode_r       <= MODE_PULSE;
            shd_period_r <= CNT_W'(DEF_PERIOD);
            shd_mode_r   <= MODE_PULSE;
            shd_valid_r  <= 1'b0;
            pulse_r      <= {CNT_W{1'b0}};
            irq_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r       <= {CNT_W{1'b0}};
                    pulse_r     <= {CNT_W{1'b0}};
                    irq_r       <= 1'b0;
                    shd_valid_r <= 1'b0;
                    period_r    <= nxt_period_s;
                    mode_r      <= nxt_mode_s;
                    state_r     <= en ? RUN : IDLE;
                end
                RUN, HOLD: begin
                    if (!en) begin
                        state_r      <= IDLE;
                        cnt_r        <= {CNT_W{1'b0}};
                        pulse_r      <= {CNT_W{1'b0}};
                        irq_r        <= 1'b0;
                        shd_period_r <= ld_period_s;
                        shd_mode_r   <= ld_mode_s;
                        shd_valid_r  <= ld_valid_s;
                    end else begin
                        cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
                        if (tick_s) begin
                            period_r    <= nxt_period_s;
                            mode_r      <= nxt_mode_s;
                            shd_valid_r <= 1'b0;
                        end else if (wr) begin
                            shd_period_r <= wr_period_s;
                            shd_mode_r   <= wr_mode;
                            shd_valid_r  <= 1'b1;
                        end
                        if (state_r == HOLD) begin
                            if (tick_s && mode_chg_s) begin
                                irq_r   <= 1'b0;
                                pulse_r <= {CNT_W{1'b0}};
                                state_r <= RUN;
                            end else if (tick_s) begin
                                irq_r <= 1'b1;
                            end else if (ack) begin
                                irq_r   <= 1'b0;
                                state_r <= RUN;
                            end
                        end else if (tick_s && (nxt_mode_s == MODE_LEVEL)) begin
                            irq_r   <= 1'b1;
                            pulse_r <= {CNT_W{1'b0}};
                            state_r <= HOLD;
                        end else if (tick_s) begin
                            irq_r   <= 1'b1;
                            pulse_r <= pw_s;
                        end else if (pulse_r > CNT_W'(1)) begin
                            pulse_r <= pulse_r - CNT_W'(1);
                        end else begin
                            irq_r   <= 1'b0;
                            pulse_r <= {CNT_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    irq_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new overrun beats a clear in the same cycle.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovr_r <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr) begin
            ovr_r <= 1'b0;
        end
    end

`ifdef PL_IRQ_MISS_CNT_EN
    logic [MISS_W-1:0] miss_r;

    // Saturating count of overrun events, restarted by the overrun clear.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            miss_r <= {MISS_W{1'b0}};
        end else if (ovr_set_s) begin
            miss_r <= ovr_clr ? MISS_W'(1) : miss_sat_inc(miss_r);
        end else if (ovr_clr) begin
            miss_r <= {MISS_W{1'b0}};
        end
    end

    assign miss_cnt = miss_r;
`endif

    assign irq     = irq_r;
    assign overrun = ovr_r;

endmodule

// File: rtl/pl_irq_timer_array.sv
// N-channel periodic PL->PS interrupt generator with per-channel period, mode and overrun.
// Define PL_IRQ_MISS_CNT_EN to add the 8-bit per-channel Miss_cnt output.
module pl_irq_timer_array
    import pl_irq_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned DEF_PERIOD = 600000,
    parameter int unsigned PULSE_CYC  = 200,
    parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                Sys_clk,
    input  logic                Rst_n,
    input  logic [N_CH-1:0]     Ch_en,
    input  logic                Cfg_wr,
    input  logic [CH_W-1:0]     Cfg_ch,
    input  logic [CNT_W-1:0]    Cfg_period,
    input  logic                Cfg_mode,
    input  logic [N_CH-1:0]     Irq_ack,
    input  logic [N_CH-1:0]     Ovr_clr,
`ifdef PL_IRQ_MISS_CNT_EN
    output logic [8*N_CH-1:0]   Miss_cnt,
`endif
    output logic [N_CH-1:0]     Irq,
    output logic [N_CH-1:0]     Irq_overrun
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_s;

        // Channel selects outside 0..N_CH-1 match no channel and are dropped.
        assign wr_s = Cfg_wr && (Cfg_ch == CH_W'(i));

        pl_irq_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .PULSE_CYC  (PULSE_CYC)
        ) u_chan (
            .Sys_clk   (Sys_clk),
            .Rst_n     (Rst_n),
            .en        (Ch_en[i]),
            .wr        (wr_s),
            .wr_period (Cfg_period),
            .wr_mode   (Cfg_mode),
            .ack       (Irq_ack[i]),
            .ovr_clr   (Ovr_clr[i]),
            .irq       (Irq[i]),
`ifdef PL_IRQ_MISS_CNT_EN
            .miss_cnt  (Miss_cnt[8*i +: 8]),
`endif
            .overrun   (Irq_overrun[i])
        );
    end

endmodule

// File: tb/tb_pl_irq_timer_array.sv
// Self-checking bench for pl_irq_timer_array (2 channels, 8-bit counter, period 10, pulse 3).
// Miss_cnt checks are included when PL_IRQ_MISS_CNT_EN is defined.
module tb_pl_irq_timer_array;

    logic       Sys_clk;
    logic       Rst_n;
    logic [1:0] Ch_en;
    logic       Cfg_wr;
    logic [0:0] Cfg_ch;
    logic [7:0] Cfg_period;
    logic       Cfg_mode;
    logic [1:0] Irq_ack;
    logic [1:0] Ovr_clr;
    logic [1:0] irq;
    logic [1:0] irq_overrun;
`ifdef PL_IRQ_MISS_CNT_EN
    logic [15:0] miss_cnt;
`endif

    pl_irq_timer_array #(
        .N_CH       (2),
        .CNT_W      (8),
        .DEF_PERIOD (10),
        .PULSE_CYC  (3)
    ) dut (
        .Sys_clk     (Sys_clk),
        .Rst_n       (Rst_n),
        .Ch_en       (Ch_en),
        .Cfg_wr      (Cfg_wr),
        .Cfg_ch      (Cfg_ch),
        .Cfg_period  (Cfg_period),
        .Cfg_mode    (Cfg_mode),
        .Irq_ack     (Irq_ack),
        .Ovr_clr     (Ovr_clr),
`ifdef PL_IRQ_MISS_CNT_EN
        .Miss_cnt    (miss_cnt),
`endif
        .Irq         (irq),
        .Irq_overrun (irq_overrun)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        string name;
        bit    do_cfg;
        int    per;
        bit    mode;
        int    ack_a;
        int    ack_b;
        int    wa_c;
        int    wa_p;
        bit    wa_m;
        int    wb_c;
        int    wb_p;
        bit    wb_m;
        string exp_irq;
        string exp_ovr;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] irq;
        logic [1:0] ovr;
    } exp_t;

    exp_t  sb_q[$];
    vec_t  vecs[9];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    function automatic vec_t mk(string name, bit do_cfg, int per, bit mode, int ack_a, int ack_b,
                                int wa_c, int wa_p, bit wa_m, int wb_c, int wb_p, bit wb_m,
                                string exp_irq, string exp_ovr);
        vec_t v;
        v.name = name; v.do_cfg = do_cfg; v.per = per; v.mode = mode;
        v.ack_a = ack_a; v.ack_b = ack_b;
        v.wa_c = wa_c; v.wa_p = wa_p; v.wa_m = wa_m;
        v.wb_c = wb_c; v.wb_p = wb_p; v.wb_m = wb_m;
        v.exp_irq = exp_irq; v.exp_ovr = exp_ovr;
        return v;
    endfunction

    // Waveform strings: one char per cycle from cycle 0, '_' is only a visual separator.
    function automatic int wave_len(string s);
        int n = 0;
        for (int i = 0; i < s.len(); i++) if (s[i] != "_") n++;
        return n;
    endfunction

    function automatic logic wave_bit(string s, int k);
        int n = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] != "_") begin
                if (n == k) return (s[i] == "1");
                n++;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Sys_clk);
        #1;
        cyc++;
        Cfg_wr  = 1'b0;
        Irq_ack = 2'b00;
        Ovr_clr = 2'b00;
    endtask

    task automatic at(int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic do_reset();
        @(posedge Sys_clk);
        #1;
        Rst_n = 1'b0; Ch_en = 2'b00; Cfg_wr = 1'b0; Cfg_ch = 1'b0;
        Irq_ack = 2'b00; Ovr_clr = 2'b00;
        repeat (2) @(posedge Sys_clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        exp_t e;
        int   n;
        n = wave_len(v.exp_irq);
        do_reset();
        if (v.do_cfg) begin
            Cfg_wr = 1'b1; Cfg_ch = 1'b0; Cfg_period = 8'(v.per); Cfg_mode = v.mode;
        end
        next_cycle();
        cyc = 0;
        Ch_en = 2'b01;
        for (int k = 0; k < n; k++) begin
            if (k > 0) next_cycle();
            if (k == v.ack_a || k == v.ack_b) Irq_ack = 2'b01;
            if (k == v.wa_c) begin
                Cfg_wr = 1'b1; Cfg_ch = 1'b0; Cfg_period = 8'(v.wa_p); Cfg_mode = v.wa_m;
            end
            if (k == v.wb_c) begin
                Cfg_wr = 1'b1; Cfg_ch = 1'b0; Cfg_period = 8'(v.wb_p); Cfg_mode = v.wb_m;
            end
            e.cyc = k;
            e.irq = {1'b0, wave_bit(v.exp_irq, k)};
            e.ovr = {1'b0, wave_bit(v.exp_ovr, k)};
            sb_q.push_back(e);
            @(negedge Sys_clk);
            e = sb_q.pop_front();
            checks++;
            if (irq !== e.irq || irq_overrun !== e.ovr) begin
                failures++;
                $display("FAIL %s cyc=%0d irq=%b ovr=%b expected irq=%b ovr=%b",
                         v.name, e.cyc, irq, irq_overrun, e.irq, e.ovr);
            end
        end
        Ch_en = 2'b00;
    endtask

    initial begin
        Rst_n = 1'b0; Ch_en = 2'b00; Cfg_wr = 1'b0; Cfg_ch = 1'b0; Cfg_period = 8'd0;
        Cfg_mode = 1'b0; Irq_ack = 2'b00; Ovr_clr = 2'b00;
        repeat (2) @(posedge Sys_clk);
        @(negedge Sys_clk);
        chk("reset_irq", {6'd0, irq}, 8'd0);
        chk("reset_ovr", {6'd0, irq_overrun}, 8'd0);

        vecs[0] = mk("lvl_ack_low_then_high", 1'b1, 10, 1'b1, 5, 14, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0000000000_0111100000_011111", "");
        vecs[1] = mk("pulse_default", 1'b0, 0, 1'b0, -1, -1, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0000000000_0111000000_0111000000_011100", "");
        vecs[2] = mk("lvl_no_ack", 1'b1, 10, 1'b1, -1, -1, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0000000000_0111111111_1111111111_111111",
                     "0000000000_0000000000_0111111111_111111");
        vecs[3] = mk("lvl_ack_at_tick", 1'b1, 10, 1'b1, 20, 25, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0000000000_0111111111_1111110000_011111", "");
        vecs[4] = mk("pulse_per1", 1'b1, 1, 1'b0, -1, -1, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0001010101_0101010101", "");
        vecs[5] = mk("pulse_per0", 1'b1, 0, 1'b0, -1, -1, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0001010101_0101010101", "");
        vecs[6] = mk("pulse_per4_clamp", 1'b1, 4, 1'b0, 6, -1, -1, 0, 1'b0, -1, 0, 1'b0,
                     "0000011101_1101110111", "");
        vecs[7] = mk("shadow_last_wins", 1'b0, 0, 1'b0, -1, -1, 3, 7, 1'b0, 5, 5, 1'b0,
                     "0000000000_0111001110_0111001110", "");
        vecs[8] = mk("mode_chg_in_hold", 1'b1, 10, 1'b1, -1, -1, 15, 10, 1'b0, -1, 0, 1'b0,
                     "0000000000_0111111111_1000000000_011100", "");
        foreach (vecs[i]) run_vec(vecs[i]);

        // Level mode overrun, clear, set-beats-clear, disable retention, async reset.
        do_reset();
        Cfg_wr = 1'b1; Cfg_ch = 1'b0; Cfg_period = 8'd10; Cfg_mode = 1'b1;
        next_cycle();
        cyc = 0;
        Ch_en = 2'b01;
        at(20); @(negedge Sys_clk);
        chk("ovr_before_2nd_tick", {6'd0, irq_overrun}, 8'd0);
        at(21); @(negedge Sys_clk);
        chk("ovr_after_2nd_tick", {6'd0, irq_overrun}, 8'd1);
`ifdef PL_IRQ_MISS_CNT_EN
        chk("miss_first", miss_cnt[7:0], 8'd1);
        chk("miss_ch1_idle", miss_cnt[15:8], 8'd0);
`endif
        at(25); Ovr_clr = 2'b01;
        at(26); @(negedge Sys_clk);
        chk("ovr_cleared", {6'd0, irq_overrun}, 8'd0);
        chk("irq_held_after_clr", {6'd0, irq}, 8'd1);
`ifdef PL_IRQ_MISS_CNT_EN
        chk("miss_cleared", miss_cnt[7:0], 8'd0);
`endif
        at(31); @(negedge Sys_clk);
        chk("ovr_reset_again", {6'd0, irq_overrun}, 8'd1);
`ifdef PL_IRQ_MISS_CNT_EN
        chk("miss_after_clear", miss_cnt[7:0], 8'd1);
`endif
        at(40); Ovr_clr = 2'b01;
        at(41); @(negedge Sys_clk);
        chk("ovr_set_beats_clr", {6'd0, irq_overrun}, 8'd1);
        at(43); Ch_en = 2'b00;
        at(44); @(negedge Sys_clk);
        chk("disable_irq_low", {6'd0, irq}, 8'd0);
        chk("disable_ovr_kept", {6'd0, irq_overrun}, 8'd1);
        at(46); Ch_en = 2'b01;
        at(56); @(negedge Sys_clk);
        chk("reenable_before_tick", {6'd0, irq}, 8'd0);
        at(57); @(negedge Sys_clk);
        chk("reenable_first_irq", {6'd0, irq}, 8'd1);
        at(58);
        Rst_n = 1'b0;
        #1;
        chk("async_rst_irq", {6'd0, irq}, 8'd0);
        chk("async_rst_ovr", {6'd0, irq_overrun}, 8'd0);
`ifdef PL_IRQ_MISS_CNT_EN
        chk("async_rst_miss", miss_cnt[7:0], 8'd0);
`endif

        // Reset in the middle of a pulse, then the counter restarts from 0 at default period.
        do_reset();
        next_cycle();
        cyc = 0;
        Ch_en = 2'b01;
        at(12); @(negedge Sys_clk);
        chk("pulse_mid_high", {6'd0, irq}, 8'd1);
        Rst_n = 1'b0;
        #1;
        chk("pulse_mid_rst", {6'd0, irq}, 8'd0);
        Ch_en = 2'b00;
        @(posedge Sys_clk);
        #1;
        Rst_n = 1'b1;
        cyc = 0;
        Ch_en = 2'b01;
        at(10); @(negedge Sys_clk);
        chk("restart_before_tick", {6'd0, irq}, 8'd0);
        at(11); @(negedge Sys_clk);
        chk("restart_first_irq", {6'd0, irq}, 8'd1);

        // Channel decode: ch1 at period 4, ch0 at default 10, both running.
        do_reset();
        Cfg_wr = 1'b1; Cfg_ch = 1'b1; Cfg_period = 8'd4; Cfg_mode = 1'b0;
        next_cycle();
        cyc = 0;
        Ch_en = 2'b11;
        at(5);  @(negedge Sys_clk); chk("two_ch_c5",  {6'd0, irq}, 8'd2);
        at(8);  @(negedge Sys_clk); chk("two_ch_c8",  {6'd0, irq}, 8'd0);
        at(11); @(negedge Sys_clk); chk("two_ch_c11", {6'd0, irq}, 8'd3);
        at(12); @(negedge Sys_clk); chk("two_ch_c12", {6'd0, irq}, 8'd1);
        Ch_en = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
